// File: rtl/sync_shape_wr_arb_pkg.sv
// rtl/sync_shape_wr_arb_pkg.sv - shared FSM encoding and half-select constants
package sync_shape_wr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Which half of an SRAM word the granted stream is expected to deliver next
   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sync_shape_wr_arb_rr_arb.sv
// rtl/sync_shape_wr_arb_rr_arb.sv - combinational round-robin picker, one-hot grant
module rr_arb #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   gnt_rot;
   logic [2*N-1:0] gnt_dbl;

   // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back
   always_comb begin
      req_dbl = {req_i, req_i} >> ptr_i;
      req_rot = req_dbl[N-1:0];
      gnt_rot = req_rot & ~(req_rot - N'(1));
      gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
      gnt_o   = gnt_dbl[2*N-1:N];
   end

endmodule

// File: rtl/sync_shape_wr_arb.sv
// rtl/sync_shape_wr_arb.sv - packs half-word beats from N streams into SRAM writes
module sync_shape_wr_arb
   import sync_shape_wr_arb_pkg::*;
#(
   parameter int SRAM_WIDTH = 256,
   parameter int NUM_OUT    = 4,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cfg_vld,
   output logic                            cfg_rdy,
   input  logic [NUM_OUT*ADDR_WIDTH-1:0]   cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]           cfg_num_word,
   input  logic [NUM_OUT*SRAM_WIDTH/2-1:0] in_data,
   input  logic [NUM_OUT-1:0]              in_data_vld,
   output logic [NUM_OUT-1:0]              in_data_rdy,
   output logic [ADDR_WIDTH-1:0]           sram_wr_addr,
   output logic [SRAM_WIDTH-1:0]           sram_wr_data,
   output logic                            sram_wr_vld,
   input  logic                            sram_wr_rdy,
   output logic                            done
);

   localparam int HW = SRAM_WIDTH / 2;
   localparam int PW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] base_q  [NUM_OUT];
   logic [ADDR_WIDTH-1:0] count_q [NUM_OUT];
   logic [ADDR_WIDTH-1:0] num_word_q;
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         gidx_q;
   logic                  half_q;
   logic [HW-1:0]         lo_q;
   logic                  wr_vld_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [SRAM_WIDTH-1:0] wr_data_q;
   logic [PW-1:0]         wr_sid_q;

   logic                  run;
   logic                  cfg_fire;
   logic                  wr_acc;
   logic                  all_done;
   logic [NUM_OUT-1:0]    elig;
   logic [NUM_OUT-1:0]    arb_gnt;
   logic                  arb_any;
   logic [PW-1:0]         arb_idx;
   logic [PW-1:0]         g_idx;
   logic                  g_any;
   logic                  hi_ok;
   logic                  beat_acc;
   logic                  acc_lo;
   logic                  acc_hi;
   logic [HW-1:0]         beat;
   logic                  g_pend;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [PW-1:0]         ptr_d;

   assign run          = (state_q == ST_RUN);
   assign cfg_rdy      = (state_q == ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign cfg_fire     = cfg_vld && cfg_rdy;
   assign wr_acc       = wr_vld_q && sram_wr_rdy;
   assign sram_wr_vld  = wr_vld_q;
   assign sram_wr_addr = wr_addr_q;
   assign sram_wr_data = wr_data_q;

   // A word sitting in the output register already counts against its stream's quota
   always_comb begin
      elig     = '0;
      all_done = 1'b1;
      for (int i = 0; i < NUM_OUT; i++) begin
         elig[i] = in_data_vld[i] &&
                   (({1'b0, count_q[i]} +
                     {{ADDR_WIDTH{1'b0}}, (wr_vld_q && (wr_sid_q == PW'(i)))})
                    < {1'b0, num_word_q});
         if (count_q[i] != num_word_q) all_done = 1'b0;
      end
   end

   rr_arb #(.N(NUM_OUT), .PW(PW)) u_rr_arb (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt)
   );

   // One-hot grant to index
   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (arb_gnt[i]) arb_idx = PW'(i);
      end
   end

   assign arb_any = |arb_gnt;
   assign g_idx   = (half_q == HALF_HI) ? gidx_q : arb_idx;
   assign g_any   = (half_q == HALF_HI) || arb_any;
   assign hi_ok   = !wr_vld_q || sram_wr_rdy;

   // Ready only to the granted stream; second half also needs room in the output register
   always_comb begin
      in_data_rdy = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         in_data_rdy[i] = run && g_any && (g_idx == PW'(i)) &&
                          ((half_q == HALF_LO) || hi_ok);
      end
   end

   assign beat_acc  = |(in_data_vld & in_data_rdy);
   assign acc_lo    = beat_acc && (half_q == HALF_LO);
   assign acc_hi    = beat_acc && (half_q == HALF_HI);
   assign beat      = in_data[int'(g_idx)*HW +: HW];
   assign g_pend    = wr_vld_q && (wr_sid_q == g_idx);
   assign load_addr = base_q[g_idx] + count_q[g_idx] + ADDR_WIDTH'(g_pend);
   assign ptr_d     = (g_idx == PW'(NUM_OUT - 1)) ? '0 : g_idx + PW'(1);

   // Control FSM and configuration latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         num_word_q <= '0;
         for (int i = 0; i < NUM_OUT; i++) base_q[i] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_vld) begin
                  state_q    <= ST_RUN;
                  num_word_q <= cfg_num_word;
                  for (int i = 0; i < NUM_OUT; i++)
                     base_q[i] <= cfg_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               end
            end
            ST_RUN: begin
               if (all_done && !wr_vld_q && (half_q == HALF_LO)) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Half-word assembly, grant lock and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_q <= HALF_LO;
         gidx_q <= '0;
         lo_q   <= '0;
         ptr_q  <= '0;
      end else if (cfg_fire) begin
         half_q <= HALF_LO;
         ptr_q  <= '0;
      end else if (acc_lo) begin
         half_q <= HALF_HI;
         gidx_q <= g_idx;
         lo_q   <= beat;
      end else if (acc_hi) begin
         half_q <= HALF_LO;
         ptr_q  <= ptr_d;
      end
   end

   // Single-entry output register towards the SRAM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_sid_q  <= '0;
      end else if (acc_hi) begin
         wr_vld_q  <= 1'b1;
         wr_addr_q <= load_addr;
         wr_data_q <= {beat, lo_q};
         wr_sid_q  <= g_idx;
      end else if (wr_acc) begin
         wr_vld_q  <= 1'b0;
      end
   end

   // Per-stream written-word counters, advanced when the SRAM takes a write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OUT; i++) count_q[i] <= '0;
      end else if (cfg_fire) begin
         for (int i = 0; i < NUM_OUT; i++) count_q[i] <= '0;
      end else if (wr_acc) begin
         count_q[wr_sid_q] <= count_q[wr_sid_q] + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_sync_shape_wr_arb.sv
// tb/tb_sync_shape_wr_arb.sv - directed self-checking bench for sync_shape_wr_arb
module tb_sync_shape_wr_arb;

   localparam int SW = 256;
   localparam int NO = 4;
   localparam int AW = 16;
   localparam int HW = SW / 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_vld;
   logic             cfg_rdy;
   logic [NO*AW-1:0] cfg_base_addr;
   logic [AW-1:0]    cfg_num_word;
   logic [NO*HW-1:0] in_data;
   logic [NO-1:0]    in_data_vld;
   logic [NO-1:0]    in_data_rdy;
   logic [AW-1:0]    sram_wr_addr;
   logic [SW-1:0]    sram_wr_data;
   logic             sram_wr_vld;
   logic             sram_wr_rdy;
   logic             done;

   logic [NO-1:0]    src_mask;
   int               bidx [NO];
   logic [NO-1:0]    acc_q;
   logic [AW-1:0]    wa_log [$];
   logic [SW-1:0]    wd_log [$];
   int               done_cnt;
   int               checks = 0;
   int               errors = 0;
   int               bases [NO] = '{0, 16, 32, 48};

   sync_shape_wr_arb #(.SRAM_WIDTH(SW), .NUM_OUT(NO), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_vld       (cfg_vld),
      .cfg_rdy       (cfg_rdy),
      .cfg_base_addr (cfg_base_addr),
      .cfg_num_word  (cfg_num_word),
      .in_data       (in_data),
      .in_data_vld   (in_data_vld),
      .in_data_rdy   (in_data_rdy),
      .sram_wr_addr  (sram_wr_addr),
      .sram_wr_data  (sram_wr_data),
      .sram_wr_vld   (sram_wr_vld),
      .sram_wr_rdy   (sram_wr_rdy),
      .done          (done)
   );

   always #5 clk = ~clk;

   function automatic logic [HW-1:0] beat(input int s, input int b);
      return HW'({s[7:0], b[15:0]});
   endfunction

   function automatic logic [SW-1:0] word_of(input int s, input int b);
      return {beat(s, b + 1), beat(s, b)};
   endfunction

   function automatic logic [AW-1:0] got_addr(input int k);
      return (k < wa_log.size()) ? wa_log[k] : 'x;
   endfunction

   function automatic logic [SW-1:0] got_data(input int k);
      return (k < wd_log.size()) ? wd_log[k] : 'x;
   endfunction

   assign in_data_vld = src_mask;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < NO; i++) in_data[i*HW +: HW] = beat(i, bidx[i]);
   end

   always @(negedge clk) begin
      acc_q = in_data_vld & in_data_rdy;
      if (sram_wr_vld && sram_wr_rdy) begin
         wa_log.push_back(sram_wr_addr);
         wd_log.push_back(sram_wr_data);
      end
      if (done) done_cnt++;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NO; i++) if (acc_q[i]) bidx[i]++;
   end

   task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                         input logic [AW-1:0] b2, input logic [AW-1:0] b3,
                         input logic [AW-1:0] n);
      cyc();
      cfg_base_addr = {b3, b2, b1, b0};
      cfg_num_word  = n;
      cfg_vld       = 1'b1;
      @(negedge clk);
      chk("cfg_rdy_idle", cfg_rdy, 1);
      cyc();
      cfg_vld = 1'b0;
   endtask

   task automatic clear_logs();
      wa_log.delete();
      wd_log.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset();
      src_mask = '0;
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      clear_logs();
      for (int i = 0; i < NO; i++) bidx[i] = 0;
   endtask

   task automatic wait_wr(input int n);
      int t = 0;
      while (wa_log.size() < n && t < 400) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("wr_count_reached", wa_log.size() >= n, 1);
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cnt == 0 && t < 400) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("done_seen", done_cnt > 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      int t;
      cfg_vld       = 1'b0;
      cfg_base_addr = '0;
      cfg_num_word  = '0;
      src_mask      = '0;
      sram_wr_rdy   = 1'b1;
      acc_q         = '0;
      done_cnt      = 0;
      for (int i = 0; i < NO; i++) bidx[i] = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cfg_rdy", cfg_rdy, 1);
      chk("rst_wr_vld", sram_wr_vld, 0);
      chk("rst_wr_addr", sram_wr_addr, 0);
      chk("rst_wr_data", sram_wr_data, 0);
      chk("rst_in_rdy", in_data_rdy, 0);
      chk("rst_done", done, 0);
      cyc();
      rst_n = 1'b1;

      // all streams valid, round-robin word interleave
      src_mask = 4'hF;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd2);
      wait_done();
      repeat (3) cyc();
      chk("rr_wr_count", wa_log.size(), 8);
      for (int k = 0; k < 8; k++) begin
         chk("rr_addr", got_addr(k), AW'(bases[k % 4] + k / 4));
         chk("rr_data", got_data(k), word_of(k % 4, 2 * (k / 4)));
      end
      chk("rr_done_once", done_cnt, 1);
      chk("rr_back_idle", cfg_rdy, 1);
      do_reset();

      // single stream, address wrap
      src_mask = 4'b0100;
      do_cfg(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'd3);
      wait_wr(3);
      chk("wrap_addr0", got_addr(0), 16'hFFFE);
      chk("wrap_addr1", got_addr(1), 16'hFFFF);
      chk("wrap_addr2", got_addr(2), 16'h0000);
      chk("wrap_data0", got_data(0), word_of(2, 0));
      chk("wrap_data1", got_data(1), word_of(2, 2));
      chk("wrap_data2", got_data(2), word_of(2, 4));
      do_reset();

      // SRAM backpressure with a word pending
      sram_wr_rdy = 1'b0;
      src_mask = 4'b0001;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd2);
      t = 0;
      while (!sram_wr_vld && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("bp_vld_rise", sram_wr_vld, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_vld_hold", sram_wr_vld, 1);
         chk("bp_addr_hold", sram_wr_addr, 0);
         chk("bp_data_hold", sram_wr_data, word_of(0, 0));
         chk("bp_hi_rdy_low", in_data_rdy, 0);
      end
      chk("bp_first_half_taken", bidx[0], 3);
      cyc();
      sram_wr_rdy = 1'b1;
      wait_wr(2);
      chk("bp_addr0", got_addr(0), 16'd0);
      chk("bp_addr1", got_addr(1), 16'd1);
      chk("bp_data1", got_data(1), word_of(0, 2));
      do_reset();

      // zero words configured
      src_mask = 4'hF;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd0);
      @(negedge clk);
      chk("zero_done_c1", done, 0);
      @(negedge clk);
      chk("zero_done_c2", done, 1);
      @(negedge clk);
      chk("zero_done_c3", done, 0);
      chk("zero_idle", cfg_rdy, 1);
      repeat (5) cyc();
      chk("zero_no_writes", wa_log.size(), 0);
      chk("zero_done_once", done_cnt, 1);
      do_reset();

      // reset after the first half of a word
      src_mask = 4'b0001;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd1);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("mrst_wr_vld", sram_wr_vld, 0);
      chk("mrst_wr_addr", sram_wr_addr, 0);
      chk("mrst_wr_data", sram_wr_data, 0);
      chk("mrst_in_rdy", in_data_rdy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_cfg_rdy", cfg_rdy, 1);
      cyc();
      rst_n = 1'b1;
      clear_logs();
      repeat (3) cyc();
      chk("mrst_no_write", wa_log.size(), 0);
      src_mask = 4'hF;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd1);
      wait_done();
      chk("mrst_addr0", got_addr(0), 16'd0);
      chk("mrst_data0", got_data(0), word_of(0, 1));
      chk("mrst_addr1", got_addr(1), 16'd16);
      do_reset();

      // grant lock while the granted stream stalls between halves
      src_mask = 4'b0011;
      do_cfg(16'd0, 16'd16, 16'd32, 16'd48, 16'd2);
      t = 0;
      while (!(in_data_vld[1] && in_data_rdy[1]) && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("lock_s1_lo_taken", in_data_vld[1] && in_data_rdy[1], 1);
      cyc();
      src_mask = 4'b0001;
      repeat (3) begin
         @(negedge clk);
         chk("lock_rdy_s1", in_data_rdy, 4'b0010);
      end
      chk("lock_s0_beats", bidx[0], 2);
      cyc();
      src_mask = 4'b0011;
      wait_wr(2);
      chk("lock_addr1", got_addr(1), 16'd16);
      chk("lock_data1", got_data(1), word_of(1, 0));
      src_mask = 4'hF;
      wait_done();
      repeat (3) cyc();
      chk("lock_done_once", done_cnt, 1);
      chk("lock_wr_total", wa_log.size(), 8);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
